// File: rtl/div_pkg.sv
// Shared types and constants for the non-restoring divider and its adder/subtractor stage.
package div_pkg;
   localparam int DIV_WIDTH = 8;
   localparam int DIV_ITERS = 8;

   localparam logic OP_ADD = 1'b1;
   localparam logic OP_SUB = 1'b0;

   localparam logic [DIV_WIDTH-1:0] DIV0_Q = 8'hFF;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      CORR,
      DONE
   } state_t;
endpackage

// File: rtl/non_restoring_div_ctrl_if.sv
// Operand/result handshake bundle for the divider; master is the producer/consumer side.
interface non_restoring_div_ctrl_if;
   import div_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [DIV_WIDTH-1:0] dividend;
   logic [DIV_WIDTH-1:0] divisor;
   logic                 out_valid;
   logic                 out_ready;
   logic [DIV_WIDTH-1:0] quotient;
   logic [DIV_WIDTH-1:0] remainder;
   logic                 div_by_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/parallel_adder_subtractor.sv
// 8-bit add/subtract with a sign-extension bit; {sign_out,result} = {sign_in,x} +/- y modulo 2^9.
// Purely combinational, no handshake.
module parallel_adder_subtractor
   import div_pkg::*;
(
   input  logic                 sign_in,
   input  logic [DIV_WIDTH-1:0] x,
   input  logic [DIV_WIDTH-1:0] y,
   input  logic                 operation_type,
   output logic [DIV_WIDTH-1:0] result,
   output logic                 sign_out
);
   logic [DIV_WIDTH:0] sum;

   always_comb begin
      if (operation_type == OP_ADD)
         sum = {sign_in, x} + {1'b0, y};
      else
         sum = {sign_in, x} - {1'b0, y};
   end

   assign {sign_out, result} = sum;
endmodule

// File: rtl/non_restoring_div_ctrl.sv
// Unsigned 8-bit non-restoring divider: 8 ITER cycles + 1 CORR cycle, result 10 cycles after accept
// (1 cycle for divide-by-zero); one op in flight, result held in DONE until out_ready.
module non_restoring_div_ctrl
   import div_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   non_restoring_div_ctrl_if.slave  bus
);
   if (WIDTH != DIV_WIDTH) begin : g_width_chk
      $error("non_restoring_div_ctrl: WIDTH must be 8 to match the adder/subtractor stage");
   end
   if ((1 << CNT_W) <= WIDTH) begin : g_cnt_chk
      $error("non_restoring_div_ctrl: CNT_W too small for WIDTH iterations");
   end

   state_t             state_q, state_d;
   logic [WIDTH:0]     a_q;
   logic [WIDTH-1:0]   q_q, m_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   quot_q, rem_q;
   logic               dz_q;

   logic               as_sign_in, as_op, as_sign_out;
   logic [WIDTH-1:0]   as_x, as_y, as_result;

   parallel_adder_subtractor u_addsub (
      .sign_in        (as_sign_in),
      .x              (as_x),
      .y              (as_y),
      .operation_type (as_op),
      .result         (as_result),
      .sign_out       (as_sign_out)
   );

   always_ff @(posedge clk) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next state plus adder operand selection: ITER shifts A:Q left by one, CORR restores a negative A.
   always_comb begin
      state_d    = state_q;
      as_sign_in = 1'b0;
      as_x       = '0;
      as_y       = m_q;
      as_op      = OP_SUB;
      case (state_q)
         IDLE: begin
            if (bus.in_valid)
               state_d = (bus.divisor == '0) ? DONE : ITER;
         end
         ITER: begin
            as_sign_in = a_q[WIDTH-1];
            as_x       = {a_q[WIDTH-2:0], q_q[WIDTH-1]};
            as_op      = a_q[WIDTH] ? OP_ADD : OP_SUB;
            if (cnt_q == CNT_W'(DIV_ITERS - 1))
               state_d = CORR;
         end
         CORR: begin
            as_sign_in = a_q[WIDTH];
            as_x       = a_q[WIDTH-1:0];
            as_op      = OP_ADD;
            state_d    = DONE;
         end
         DONE: begin
            if (bus.out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q    <= '0;
         q_q    <= '0;
         m_q    <= '0;
         cnt_q  <= '0;
         quot_q <= '0;
         rem_q  <= '0;
         dz_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  if (bus.divisor != '0) begin
                     a_q   <= '0;
                     q_q   <= bus.dividend;
                     m_q   <= bus.divisor;
                     cnt_q <= '0;
                  end else begin
                     quot_q <= DIV0_Q;
                     rem_q  <= bus.dividend;
                     dz_q   <= 1'b1;
                  end
               end
            end
            ITER: begin
               a_q   <= {as_sign_out, as_result};
               q_q   <= {q_q[WIDTH-2:0], ~as_sign_out};
               cnt_q <= cnt_q + 1'b1;
            end
            CORR: begin
               if (a_q[WIDTH])
                  a_q <= {as_sign_out, as_result};
               quot_q <= q_q;
               rem_q  <= a_q[WIDTH] ? as_result : a_q[WIDTH-1:0];
               dz_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready    = (state_q == IDLE);
   assign bus.out_valid   = (state_q == DONE);
   assign bus.quotient    = quot_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_non_restoring_div_ctrl.sv
// Self-checking bench for non_restoring_div_ctrl: directed table, handshake corner cases, random sweep.
module tb_non_restoring_div_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   non_restoring_div_ctrl_if bus ();

   non_restoring_div_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
   } vec_t;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
      int         lat;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[10];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [7:0] q, input logic [7:0] r, input logic dz);
      exp_t e;
      e.q   = q;
      e.r   = r;
      e.dz  = dz;
      e.lat = dz ? 1 : 10;
      sb.push_back(e);
   endtask

   // Present an operation and return one cycle after the accepting edge.
   task automatic start_op(input logic [7:0] a, input logic [7:0] b);
      int waited = 0;
      bus.in_valid = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      while (!bus.in_ready && waited < 40) begin
         step();
         waited++;
      end
      if (!bus.in_ready)
         chk("accept_timeout", 0, 1);
      step();
      bus.in_valid = 1'b0;
   endtask

   // Wait for out_valid, pop the scoreboard and compare; does not advance past the DONE cycle.
   task automatic collect(input bit check_lat);
      int   lat = 1;
      exp_t e;
      while (!bus.out_valid && lat < 40) begin
         step();
         lat++;
      end
      if (!bus.out_valid) begin
         chk("result_timeout", 0, 1);
      end else if (sb.size() == 0) begin
         chk("unexpected_result", 1, 0);
      end else begin
         e = sb.pop_front();
         if (check_lat)
            chk("latency", lat, e.lat);
         chk("quotient", int'(bus.quotient), int'(e.q));
         chk("remainder", int'(bus.remainder), int'(e.r));
         chk("div_by_zero", int'(bus.div_by_zero), int'(e.dz));
      end
   endtask

   initial begin
      int ov_seen;
      logic [7:0] ra, rb;

      vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,   dz: 1'b0};
      vecs[1] = '{a: 8'd7,   b: 8'd100, q: 8'd0,   r: 8'd7,   dz: 1'b0};
      vecs[2] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   dz: 1'b0};
      vecs[3] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   dz: 1'b0};
      vecs[4] = '{a: 8'd200, b: 8'd0,   q: 8'hFF,  r: 8'd200, dz: 1'b1};
      vecs[5] = '{a: 8'd9,   b: 8'd3,   q: 8'd3,   r: 8'd0,   dz: 1'b0};
      vecs[6] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,   dz: 1'b0};
      vecs[7] = '{a: 8'd1,   b: 8'd255, q: 8'd0,   r: 8'd1,   dz: 1'b0};
      vecs[8] = '{a: 8'd128, b: 8'd2,   q: 8'd64,  r: 8'd0,   dz: 1'b0};
      vecs[9] = '{a: 8'd254, b: 8'd128, q: 8'd1,   r: 8'd126, dz: 1'b0};

      bus.in_valid  = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus.out_ready = 1'b1;

      rst_n = 1'b0;
      repeat (3) step();
      chk("rst_in_ready", int'(bus.in_ready), 1);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_quotient", int'(bus.quotient), 0);
      chk("rst_remainder", int'(bus.remainder), 0);
      chk("rst_div_by_zero", int'(bus.div_by_zero), 0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 10; i++) begin
         push_exp(vecs[i].q, vecs[i].r, vecs[i].dz);
         start_op(vecs[i].a, vecs[i].b);
         collect(1'b1);
         step();
         chk("in_ready_after_hs", int'(bus.in_ready), 1);
      end

      // Backpressure: result must hold while out_ready is low.
      bus.out_ready = 1'b0;
      push_exp(8'd8, 8'd2, 1'b0);
      start_op(8'd50, 8'd6);
      collect(1'b1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_out_valid", int'(bus.out_valid), 1);
         chk("bp_in_ready", int'(bus.in_ready), 0);
         chk("bp_quotient", int'(bus.quotient), 8);
         chk("bp_remainder", int'(bus.remainder), 2);
      end
      bus.out_ready = 1'b1;
      step();
      chk("bp_release_in_ready", int'(bus.in_ready), 1);
      chk("bp_release_out_valid", int'(bus.out_valid), 0);

      // A request presented while busy must be neither accepted nor queued.
      push_exp(8'd8, 8'd4, 1'b0);
      start_op(8'd60, 8'd7);
      bus.in_valid = 1'b1;
      bus.dividend = 8'd99;
      bus.divisor  = 8'd9;
      for (int i = 0; i < 4; i++) begin
         chk("busy_in_ready", int'(bus.in_ready), 0);
         step();
      end
      bus.in_valid = 1'b0;
      collect(1'b0);
      step();
      ov_seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.out_valid) ov_seen++;
         step();
      end
      chk("busy_not_queued", ov_seen, 0);

      // Reset in the middle of an operation aborts it.
      start_op(8'd100, 8'd7);
      repeat (3) step();
      rst_n = 1'b0;
      step();
      chk("midrst_out_valid", int'(bus.out_valid), 0);
      chk("midrst_in_ready", int'(bus.in_ready), 1);
      chk("midrst_quotient", int'(bus.quotient), 0);
      chk("midrst_remainder", int'(bus.remainder), 0);
      rst_n = 1'b1;
      step();
      push_exp(8'd3, 8'd2, 1'b0);
      start_op(8'd17, 8'd5);
      collect(1'b1);
      step();

      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(1, 255));
         push_exp(ra / rb, ra % rb, 1'b0);
         start_op(ra, rb);
         collect(1'b1);
         step();
      end

      chk("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/non_restoring_div_ctrl.md
Name: non_restoring_div_ctrl

Overview:
- Sequential control and datapath for unsigned 8-bit non-restoring division.
- Holds the partial remainder A (9-bit, sign + 8), the quotient/dividend register Q and the divisor M, plus an iteration counter.
- Each cycle it drives the shared 8-bit adder/subtractor stage and captures that stage's result.
- It sits directly upstream of the adder/subtractor, feeding it operands and the operation select.
- Valid/ready handshakes on both input and output.

Parameters:
- WIDTH, 8, operand width. Fixed to 8 because the adder/subtractor stage is 8-bit. Other values are unsupported; elaboration must fail.
- CNT_W, 4, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  dividend/divisor presented.
- in_ready  out  1  block can accept a new operation.
- dividend  in  8  unsigned dividend.
- divisor  in  8  unsigned divisor.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- quotient  out  8  unsigned quotient.
- remainder  out  8  unsigned remainder.
- div_by_zero  out  1  error flag, valid with out_valid.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at an edge):
  - state=IDLE.
  - A, Q, M, counter cleared.
  - out_valid=0, in_ready=1, div_by_zero=0, quotient=0, remainder=0.
  - Reset mid-operation aborts the operation; no output is produced.
- States: IDLE, ITER, CORR, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE:
  - Accept on in_valid & in_ready at edge T.
  - divisor!=0: A<=0, Q<=dividend, M<=divisor, cnt<=0, go to ITER.
  - divisor==0: quotient<=8'hFF, remainder<=dividend, div_by_zero<=1, go straight to DONE, so out_valid=1 at T+1.
- ITER (exactly 8 cycles, T+1..T+8), combinational operands to the adder each cycle:
  - sign_in = A[7] (bit 8 of the shifted A).
  - x = {A[6:0], Q[7]}, y = M.
  - operation_type = A[8] (old sign): 1 = add M, 0 = subtract M.
  - Edge updates: A <= {sign_out, result}; Q <= {Q[6:0], ~sign_out}; cnt <= cnt+1.
  - When cnt==7, go to CORR.
  - Arithmetic is modulo 2^9. Overflow of the intermediate 2A is intentional and cannot corrupt the result while M != 0.
- CORR (1 cycle, T+9):
  - If A[8]==1: drive operation_type=1, sign_in=A[8], x=A[7:0], y=M, and capture A <= A+M.
  - Otherwise A is unchanged.
  - At the edge: quotient<=Q, remainder<=corrected A[7:0], div_by_zero<=0, go to DONE.
- DONE:
  - out_valid=1 from T+10. Fixed latency is 10 cycles from accept.
  - quotient, remainder and div_by_zero hold stable while out_ready=0.
  - On out_valid & out_ready: go to IDLE, out_valid<=0.
  - Back-to-back throughput is one operation per 11 cycles minimum; in_ready returns to 1 the cycle after the output handshake.
- Outside DONE, quotient/remainder keep their last values and are don't-care to the consumer.
- in_valid while busy is ignored: not latched and not queued.

Decomposition:
- Shared package div_pkg:
  - State enum (IDLE, ITER, CORR, DONE).
  - Constants DIV_WIDTH=8, DIV_ITERS=8.
  - Operation encodings OP_ADD=1, OP_SUB=0 matching the adder/subtractor stage.
  - Divide-by-zero quotient constant DIV0_Q=8'hFF.
- Single sub-module: parallel_adder_subtractor, instantiated once. Its operand muxing (ITER vs CORR) lives in this block.

Test Plan:
- 100/7 -> out_valid exactly 10 cycles after accept; quotient=14, remainder=2, div_by_zero=0.
- 7/100 (final A negative, exercises CORR add) -> quotient=0, remainder=7; 255/1 -> quotient=255, remainder=0; 255/255 -> 1, 0.
- 200/0 -> out_valid at T+1, quotient=8'hFF, remainder=200, div_by_zero=1; the next op 9/3 -> 3, 0, flag cleared.
- Backpressure:
  - Hold out_ready=0 for 5 cycles on 50/6 -> outputs 8, 2 stable throughout, in_ready=0.
  - Raise out_ready -> in_ready=1 on the next cycle.
  - A second in_valid presented during busy is not accepted.
- Reset mid-op: start 100/7, assert rst_n=0 at cycle T+4 -> next edge state IDLE, out_valid=0, in_ready=1, outputs 0; then 17/5 -> 3, 2.
- Random sweep, 1000 pairs with divisor != 0, against a reference model (q = a/b, r = a%b); all match.
